ex_mdu_stage: RTL and testbench
===============================

# ex_mdu_stage

Execute stage with an integrated multi-cycle multiply/divide unit (RV32M) alongside the single-cycle ALU datapath. It sits between the ID/EX and EX/MEM pipeline registers. ALU ops complete combinationally; M-extension ops run through an internal FSM and raise `ex_stall` so the hazard unit holds upstream stages and bubbles MEM until the result is ready. `br_target` is the ALU result, as in the single-cycle stage.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; must be even and ≥ 8.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  an instruction occupies EX this cycle.
- `flush`  in  1  kill the instruction in EX and any in-flight MDU op.
- `aluop`  in  `alu_pkg::aluop_t`  ALU operation, used when `mdu_en`=0.
- `mdu_en`  in  1  the instruction is an M-extension op.
- `mduop`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `opr_a`, `opr_b`  in  DATA_WIDTH  register operands.
- `pc`, `imm`  in  DATA_WIDTH  PC and immediate.
- `opr_a_sel`, `opr_b_sel`  in  1  select `pc` for operand A / `imm` for operand B (ALU path only).
- `opr_res`  out  DATA_WIDTH  result to EX/MEM.
- `out_valid`  out  1  `opr_res` is final this cycle.
- `ex_stall`  out  1  hold the PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- `br_target`  out  DATA_WIDTH  ALU result, always driven.

## Operation
- **ALU path** (`mdu_en`=0)
  - `opr_res` is the ALU result on the muxed operands, in the same cycle.
  - `out_valid` = `in_valid` & ~`flush`; `ex_stall` = 0.
- **MDU operands:** always the raw `opr_a`/`opr_b`; the select muxes are ignored.
- **FSM states:** IDLE, MUL, DIV, DONE.
- **IDLE:**
  - On `in_valid` & `mdu_en` & ~`flush`, latch the operands and `mduop` and assert `ex_stall` combinationally.
  - Next state:
    - MUL for ops 0–3.
    - DONE for a divide special case.
    - DIV otherwise.
- **MUL (one cycle):**
  - Form a 2·DATA_WIDTH product from (DATA_WIDTH+1)-bit extended operands.
  - Sign extension: A is signed for MULH and MULHSU; B is signed for MULH only.
  - Register the low half (MUL) or the high half (others), then go to DONE.
- **DIV (DATA_WIDTH cycles):**
  - Restoring radix-2 division on magnitudes, one quotient bit per cycle, using an iteration counter.
  - Signed ops negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative.
  - After the last iteration go to DONE.
- **Divide special cases** (detected in IDLE, go straight to DONE):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^(DATA_WIDTH−1) / −1): quotient = dividend; remainder = 0.
- **DONE:**
  - `opr_res` = registered result, `out_valid` = 1, `ex_stall` = 0.
  - Next state IDLE unconditionally. The pipeline advances on this edge, so the same instruction is never re-accepted.
- **Flush:**
  - In any state, `flush` forces the next state to IDLE.
  - While `flush` is high, `ex_stall` = 0 and `out_valid` = 0.
  - The partial result is discarded.
- **Reset:**
  - Next state IDLE; counter and result registers cleared to 0.
  - While `rst` is high, `out_valid` = 0 and `ex_stall` = 0.
  - `opr_res` = 0 during reset and in MUL/DIV states.

## Timing
- ALU op: latency 0; result combinational in the accept cycle.
- MUL family: accept in cycle T (stall), MUL in T+1 (stall), DONE in T+2. Total 3 cycles in EX, 2 stall cycles.
- DIV family: accept in T, DIV in T+1 … T+DATA_WIDTH, DONE in T+DATA_WIDTH+1. Total DATA_WIDTH+2 cycles.
- Divide special case: accept in T, DONE in T+1. Total 2 cycles.
- `ex_stall` is a Mealy output: high in the accept cycle and in MUL/DIV states, low in DONE and IDLE-without-request.
- An MDU op arriving immediately after DONE is accepted in the next cycle; there is no dead cycle.
- Upstream holds all inputs stable while `ex_stall` is high. The block ignores input changes after accept.

## Configuration
- **`MDU_DIV_EN` defined:** divide/remainder ops (4–7) are implemented as above.
- **`MDU_DIV_EN` undefined:**
  - The DIV state, divider datapath and counter are not compiled.
  - Ops 4–7 take the special-case path: DONE in T+1 with `opr_res` = 0.
  - Multiply ops are unaffected.

## Test plan
- ALU ADD with `opr_a`=5, `imm`=7, `opr_b_sel`=1 → `opr_res`=12 and `out_valid`=1 in the same cycle, `ex_stall`=0, `br_target`=12.
- MULH with 0x80000000 × 0x80000000 → `ex_stall` high for 2 cycles; then `opr_res`=0x40000000 with `out_valid` for exactly 1 cycle.
- DIV −7 / 2 → `ex_stall` high for 33 cycles; then `opr_res`=0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU 123 / 0 → 0xFFFFFFFF after 2 cycles. REM 0x80000000 / −1 → 0 after 2 cycles.
- Flush asserted at DIV iteration 10 → `ex_stall` low that cycle, no `out_valid`, FSM in IDLE next cycle. A following MUL 6×7 returns 42.
- Reset asserted mid-MUL → `out_valid`=0 and `ex_stall`=0 while reset is high; back in IDLE afterward. With `MDU_DIV_EN` undefined, DIV 10/2 → 0 in 2 cycles.

Source files
------------

// File: rtl/ex_mdu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu_stage (with package alu_pkg)
// Purpose  : Execute stage with a single-cycle ALU and a multi-cycle RV32M
//            multiply/divide unit. Define MDU_DIV_EN to build the divider.
// Revision : 1.0 - initial release
// ============================================================================

package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } aluop_t;
endpackage

module ex_mdu_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  flush,
    input  alu_pkg::aluop_t       aluop,
    input  logic                  mdu_en,
    input  logic [2:0]            mduop,
    input  logic [DATA_WIDTH-1:0] opr_a,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  opr_a_sel,
    input  logic                  opr_b_sel,
    output logic [DATA_WIDTH-1:0] opr_res,
    output logic                  out_valid,
    output logic                  ex_stall,
    output logic [DATA_WIDTH-1:0] br_target
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
`ifdef MDU_DIV_EN
    localparam logic [1:0] c_DIV  = 2'd2;
`endif
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_result;

    logic [W-1:0]   w_alu_a;
    logic [W-1:0]   w_alu_b;
    logic [SW-1:0]  w_shamt;
    logic [W-1:0]   w_alu_res;
    logic           w_accept;

    // ------------------------------------------------------------------ ALU
    always_comb begin
        w_alu_a   = opr_a_sel ? pc  : opr_a;
        w_alu_b   = opr_b_sel ? imm : opr_b;
        w_shamt   = w_alu_b[SW-1:0];
        w_alu_res = '0;
        case (aluop)
            alu_pkg::ALU_ADD:   w_alu_res = w_alu_a + w_alu_b;
            alu_pkg::ALU_SUB:   w_alu_res = w_alu_a - w_alu_b;
            alu_pkg::ALU_SLL:   w_alu_res = w_alu_a << w_shamt;
            alu_pkg::ALU_SLT:   w_alu_res = {{(W-1){1'b0}}, $signed(w_alu_a) < $signed(w_alu_b)};
            alu_pkg::ALU_SLTU:  w_alu_res = {{(W-1){1'b0}}, w_alu_a < w_alu_b};
            alu_pkg::ALU_XOR:   w_alu_res = w_alu_a ^ w_alu_b;
            alu_pkg::ALU_SRL:   w_alu_res = w_alu_a >> w_shamt;
            alu_pkg::ALU_SRA:   w_alu_res = $unsigned($signed(w_alu_a) >>> w_shamt);
            alu_pkg::ALU_OR:    w_alu_res = w_alu_a | w_alu_b;
            alu_pkg::ALU_AND:   w_alu_res = w_alu_a & w_alu_b;
            alu_pkg::ALU_PASSB: w_alu_res = w_alu_b;
            default:            w_alu_res = '0;
        endcase
    end

    assign br_target = w_alu_res;

    // ------------------------------------------------------------ multiplier
    // Extending to 2W bits gives the same low 2W product bits as the (W+1)-bit
    // signed form while keeping every product bit in use.
    logic           w_mul_sa;
    logic           w_mul_sb;
    logic [2*W-1:0] w_mul_a;
    logic [2*W-1:0] w_mul_b;
    logic [2*W-1:0] w_prod;

    always_comb begin
        w_mul_sa = ((r_op == 2'd1) || (r_op == 2'd2)) & r_a[W-1];
        w_mul_sb = (r_op == 2'd1) & r_b[W-1];
        w_mul_a  = {{W{w_mul_sa}}, r_a};
        w_mul_b  = {{W{w_mul_sb}}, r_b};
        w_prod   = w_mul_a * w_mul_b;
    end

`ifdef MDU_DIV_EN
    // --------------------------------------------------------------- divider
    localparam int CW = (SW < 1) ? 1 : SW;
    localparam logic [CW-1:0] c_LAST = CW'(DATA_WIDTH - 1);

    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_dvd;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_rem;
    logic           r_neg_q;
    logic           r_neg_r;

    logic           w_neg_a;
    logic           w_neg_b;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_div_ovf;
    logic [W:0]     w_trial;
    logic           w_qbit;
    logic [W-1:0]   w_rem_nx;
    logic [W-1:0]   w_quo_nx;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;

    always_comb begin
        w_neg_a   = ~mduop[0] & opr_a[W-1];
        w_neg_b   = ~mduop[0] & opr_b[W-1];
        w_mag_a   = w_neg_a ? -opr_a : opr_a;
        w_mag_b   = w_neg_b ? -opr_b : opr_b;
        w_div_ovf = ~mduop[0] & (opr_a == {1'b1, {(W-1){1'b0}}}) & (&opr_b);
        // Top bit of the trial difference is the borrow: set means restore.
        w_trial   = {r_rem, r_dvd[W-1]} - {1'b0, r_dvs};
        w_qbit    = ~w_trial[W];
        w_rem_nx  = w_qbit ? w_trial[W-1:0] : {r_rem[W-2:0], r_dvd[W-1]};
        w_quo_nx  = {r_dvd[W-2:0], w_qbit};
        w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
    end
`endif

    // ---------------------------------------------------------------- control
    assign w_accept = (r_state == c_IDLE) & in_valid & mdu_en & ~flush;

    always_comb begin
        ex_stall  = 1'b0;
        out_valid = 1'b0;
        opr_res   = w_alu_res;
        if (rst) begin
            opr_res = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    out_valid = in_valid & ~mdu_en & ~flush;
                    ex_stall  = w_accept;
                end
                c_DONE: begin
                    out_valid = ~flush;
                    opr_res   = r_result;
                end
                default: begin
                    ex_stall = ~flush;
                    opr_res  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_result <= '0;
`ifdef MDU_DIV_EN
            r_cnt    <= '0;
`endif
        end else if (flush) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a  <= opr_a;
                        r_b  <= opr_b;
                        r_op <= mduop[1:0];
                        if (!mduop[2]) begin
                            r_state <= c_MUL;
                        end else begin
`ifdef MDU_DIV_EN
                            if (opr_b == '0) begin
                                r_result <= mduop[1] ? opr_a : '1;
                                r_state  <= c_DONE;
                            end else if (w_div_ovf) begin
                                r_result <= mduop[1] ? '0 : opr_a;
                                r_state  <= c_DONE;
                            end else begin
                                r_dvd   <= w_mag_a;
                                r_dvs   <= w_mag_b;
                                r_rem   <= '0;
                                r_cnt   <= '0;
                                r_neg_q <= w_neg_a ^ w_neg_b;
                                r_neg_r <= w_neg_a;
                                r_state <= c_DIV;
                            end
`else
                            r_result <= '0;
                            r_state  <= c_DONE;
`endif
                        end
                    end
                end
                c_MUL: begin
                    r_result <= (r_op == 2'd0) ? w_prod[W-1:0] : w_prod[2*W-1:W];
                    r_state  <= c_DONE;
                end
`ifdef MDU_DIV_EN
                c_DIV: begin
                    r_dvd <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    if (r_cnt == c_LAST) begin
                        r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                        r_state  <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_mdu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mdu_stage
// Purpose  : Self-checking bench for ex_mdu_stage (works with or without
//            MDU_DIV_EN defined).
// Revision : 1.0 - initial release
// ============================================================================

module tb_ex_mdu_stage;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            flush;
    alu_pkg::aluop_t aluop;
    logic            mdu_en;
    logic [2:0]      mduop;
    logic [DW-1:0]   opr_a, opr_b, pc, imm;
    logic            opr_a_sel, opr_b_sel;
    logic [DW-1:0]   opr_res;
    logic            out_valid;
    logic            ex_stall;
    logic [DW-1:0]   br_target;

    int n_cmp = 0;
    int n_err = 0;

    ex_mdu_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .aluop(aluop), .mdu_en(mdu_en), .mduop(mduop),
        .opr_a(opr_a), .opr_b(opr_b), .pc(pc), .imm(imm),
        .opr_a_sel(opr_a_sel), .opr_b_sel(opr_b_sel),
        .opr_res(opr_res), .out_valid(out_valid), .ex_stall(ex_stall),
        .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- reference model
    function automatic logic [31:0] alu_model(input alu_pkg::aluop_t op,
                                              input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            alu_pkg::ALU_ADD:   return a + b;
            alu_pkg::ALU_SUB:   return a - b;
            alu_pkg::ALU_SLL:   return a << sh;
            alu_pkg::ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            alu_pkg::ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            alu_pkg::ALU_XOR:   return a ^ b;
            alu_pkg::ALU_SRL:   return a >> sh;
            alu_pkg::ALU_SRA:   return $signed(a) >>> sh;
            alu_pkg::ALU_OR:    return a | b;
            alu_pkg::ALU_AND:   return a & b;
            alu_pkg::ALU_PASSB: return b;
            default:            return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mdu_model(input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
                if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return op[1] ? 32'd0 : a;
                case (op)
                    3'd4:    begin p = sa / sb; return p[31:0]; end
                    3'd5:    return a / b;
                    3'd6:    begin p = sa % sb; return p[31:0]; end
                    default: return a % b;
                endcase
`else
                if (ua != ub) return 32'd0;
                return 32'd0;
`endif
            end
        endcase
    endfunction

    // Cycles with ex_stall high for one MDU instruction.
    function automatic int mdu_stalls(input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
`ifdef MDU_DIV_EN
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DW + 1;
`else
        if (a == b) return 1;
        return 1;
`endif
    endfunction

    // ------------------------------------------------------- per-cycle compare
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res  = '0;

    always @(negedge clk) begin
        logic [31:0] e_alu;
        e_alu = alu_model(aluop, opr_a_sel ? pc : opr_a, opr_b_sel ? imm : opr_b);
        if (rst) begin
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_stall", {31'd0, ex_stall}, 32'd0);
            chk("rst_res", opr_res, 32'd0);
            m_left = 0;
            m_done = 1'b0;
        end else begin
            chk("br_target", br_target, e_alu);
            if (flush) begin
                chk("flush_valid", {31'd0, out_valid}, 32'd0);
                chk("flush_stall", {31'd0, ex_stall}, 32'd0);
                m_left = 0;
                m_done = 1'b0;
            end else if (m_done) begin
                chk("done_valid", {31'd0, out_valid}, 32'd1);
                chk("done_stall", {31'd0, ex_stall}, 32'd0);
                chk("done_res", opr_res, m_res);
                m_done = 1'b0;
            end else if (m_left > 0) begin
                chk("busy_valid", {31'd0, out_valid}, 32'd0);
                chk("busy_stall", {31'd0, ex_stall}, 32'd1);
                chk("busy_res", opr_res, 32'd0);
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (in_valid && mdu_en) begin
                chk("acc_valid", {31'd0, out_valid}, 32'd0);
                chk("acc_stall", {31'd0, ex_stall}, 32'd1);
                m_res  = mdu_model(mduop, opr_a, opr_b);
                m_left = mdu_stalls(mduop, opr_a, opr_b) - 1;
                if (m_left == 0) m_done = 1'b1;
            end else if (in_valid) begin
                chk("alu_valid", {31'd0, out_valid}, 32'd1);
                chk("alu_stall", {31'd0, ex_stall}, 32'd0);
                chk("alu_res", opr_res, e_alu);
            end else begin
                chk("idle_valid", {31'd0, out_valid}, 32'd0);
                chk("idle_stall", {31'd0, ex_stall}, 32'd0);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic idle_inputs();
        in_valid = 1'b0;
        mdu_en   = 1'b0;
        flush    = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int stalls);
        bit got;
        got      = 1'b0;
        res      = '0;
        stalls   = 0;
        in_valid = 1'b1;
        mdu_en   = 1'b1;
        mduop    = op;
        opr_a    = a;
        opr_b    = b;
        pc       = 32'hDEAD_0000;
        imm      = 32'h0000_BEEF;
        opr_a_sel = 1'b1;
        opr_b_sel = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (ex_stall) stalls++;
            if (out_valid) begin
                got = 1'b1;
                res = opr_res;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("mdu_completed", {31'd0, got}, 32'd1);
    endtask

    task automatic run_alu(input alu_pkg::aluop_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic asel, input logic bsel, input logic [31:0] exp, input string name);
        in_valid  = 1'b1;
        mdu_en    = 1'b0;
        aluop     = op;
        opr_a     = a;
        opr_b     = b;
        opr_a_sel = asel;
        opr_b_sel = bsel;
        @(negedge clk);
        chk(name, opr_res, exp);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_stall"}, {31'd0, ex_stall}, 32'd0);
        chk({name, "_br"}, br_target, exp);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] res;
        int          st;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; aluop = alu_pkg::ALU_ADD;
        mdu_en = 1'b0; mduop = 3'd0; opr_a = '0; opr_b = '0; pc = '0; imm = '0;
        opr_a_sel = 1'b0; opr_b_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ALU path
        pc = 32'd100; imm = 32'd7;
        run_alu(alu_pkg::ALU_ADD, 32'd5, 32'd99, 1'b0, 1'b1, 32'd12, "alu_add_imm");
        pc = 32'd100;
        run_alu(alu_pkg::ALU_SUB, 32'd1, 32'd30, 1'b1, 1'b0, 32'd70, "alu_sub_pc");
        run_alu(alu_pkg::ALU_SRA, 32'hF000_0000, 32'd4, 1'b0, 1'b0, 32'hFF00_0000, "alu_sra");
        run_alu(alu_pkg::ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd1, "alu_slt");

        // Multiply family
        run_mdu(3'd1, 32'h8000_0000, 32'h8000_0000, res, st);
        chk("mulh_res", res, 32'h4000_0000);
        chk("mulh_stalls", 32'(st), 32'd2);
        @(negedge clk);
        chk("mulh_single_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        run_mdu(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, st);
        chk("mulhu_res", res, 32'hFFFF_FFFE);
        run_mdu(3'd2, 32'hFFFF_FFFF, 32'd2, res, st);
        chk("mulhsu_res", res, 32'hFFFF_FFFF);

        // Back-to-back with no dead cycle
        run_mdu(3'd0, 32'h0000_FFFF, 32'h0001_0001, res, st);
        chk("mul_b2b_res", res, 32'hFFFF_FFFF);
        run_mdu(3'd5, 32'd100, 32'd7, res, st);
`ifdef MDU_DIV_EN
        chk("divu_b2b_res", res, 32'd14);
`else
        chk("divu_b2b_res", res, 32'd0);
`endif

        // Divide family
`ifdef MDU_DIV_EN
        run_mdu(3'd4, 32'hFFFF_FFF9, 32'd2, res, st);
        chk("div_res", res, 32'hFFFF_FFFD);
        chk("div_stalls", 32'(st), 32'd33);
        run_mdu(3'd6, 32'hFFFF_FFF9, 32'd2, res, st);
        chk("rem_res", res, 32'hFFFF_FFFF);
        run_mdu(3'd5, 32'd123, 32'd0, res, st);
        chk("divu0_res", res, 32'hFFFF_FFFF);
        chk("divu0_stalls", 32'(st), 32'd1);
        run_mdu(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, st);
        chk("rem_ovf_res", res, 32'd0);
        chk("rem_ovf_stalls", 32'(st), 32'd1);
        run_mdu(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, st);
        chk("div_ovf_res", res, 32'h8000_0000);
        run_mdu(3'd7, 32'd100, 32'd7, res, st);
        chk("remu_res", res, 32'd2);
        run_mdu(3'd4, 32'd100, 32'hFFFF_FFF9, res, st);
        chk("div_negb_res", res, 32'hFFFF_FFF2);
`else
        run_mdu(3'd4, 32'd10, 32'd2, res, st);
        chk("div_off_res", res, 32'd0);
        chk("div_off_stalls", 32'(st), 32'd1);
`endif

        // Flush while the unit is busy
        in_valid = 1'b1; mdu_en = 1'b1; opr_a = 32'd1000; opr_b = 32'd3;
`ifdef MDU_DIV_EN
        mduop = 3'd4;
        repeat (11) begin @(posedge clk); #1; end
`else
        mduop = 3'd0;
        @(posedge clk); #1;
`endif
        flush = 1'b1; in_valid = 1'b0; mdu_en = 1'b0;
        @(negedge clk);
        chk("flush_stall_lit", {31'd0, ex_stall}, 32'd0);
        chk("flush_valid_lit", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_stall", {31'd0, ex_stall}, 32'd0);
        chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        run_mdu(3'd0, 32'd6, 32'd7, res, st);
        chk("mul_after_flush", res, 32'd42);
        chk("mul_after_flush_stalls", 32'(st), 32'd2);

        // Reset in the middle of a multiply
        in_valid = 1'b1; mdu_en = 1'b1; mduop = 3'd0; opr_a = 32'd3; opr_b = 32'd3;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; mdu_en = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_stall", {31'd0, ex_stall}, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_stall", {31'd0, ex_stall}, 32'd0);
        chk("after_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        run_mdu(3'd0, 32'hFFFF_FFFD, 32'd5, res, st);
        chk("mul_neg_res", res, 32'hFFFF_FFF1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
